pipe_skid_reg: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake and a one-entry skid buffer, replacing the bare stall/clear stage register between pipeline stages of the MIPS core. Upstream back-pressure (`in_ready`) comes straight from a flop, so the stall path no longer ripples combinationally through the stage. Full throughput is kept: one transfer per cycle when downstream is ready. A synchronous flush (bubble insert) drops all held data.

---
 rtl/pipe_skid_reg.sv | 92 +++++++++
 tb/tb_pipe_skid_reg.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a valid/ready handshake and a one-entry skid buffer.
// Every output comes from a flop, so back-pressure never ripples combinationally through the stage.
module pipe_skid_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Data_In,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Data_Out,
  output logic [1:0]       occupancy
);

  // The state encoding equals the number of held entries, so occupancy is the state flop itself.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]       state, state_next;
  logic [WIDTH-1:0] main_q, main_next;
  logic [WIDTH-1:0] skid_q, skid_next;
  logic             in_ready_q, out_valid_q;
  logic             accept, fire;

  assign accept = in_valid && in_ready_q;
  assign fire   = out_valid_q && out_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_next = state;
    main_next  = main_q;
    skid_next  = skid_q;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          main_next  = Data_In;
          state_next = ONE;
        end
      end
      ONE: begin
        if (accept && fire) begin
          main_next = Data_In;
        end else if (accept) begin
          skid_next  = Data_In;
          state_next = TWO;
        end else if (fire) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (fire) begin
          main_next  = skid_q;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
    // Flush wins over any accept or fire decided above; skid contents become don't-care.
    if (flush) begin
      state_next = EMPTY;
      main_next  = RESET_VALUE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      state       <= EMPTY;
      main_q      <= RESET_VALUE;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      main_q      <= main_next;
      skid_q      <= skid_next;
      in_ready_q  <= (state_next != TWO);
      out_valid_q <= (state_next != EMPTY);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Data_Out  = main_q;
  assign occupancy = state;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios on a 64-bit stage, then random traffic on 8- and 64-bit stages.
// A FIFO scoreboard per instance is loaded on accept and compared on fire.
module tb_pipe_skid_reg;

  logic clk = 1'b0;
  logic reset, flush;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  data_in8, data_out8;
  logic [1:0]  occ8;
  logic        in_valid64, in_ready64, out_valid64, out_ready64;
  logic [63:0] data_in64, data_out64;
  logic [1:0]  occ64;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  q8[$];
  logic [63:0] q64[$];

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(8), .RESET_VALUE(8'hA5)) u8 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid8), .in_ready(in_ready8), .Data_In(data_in8),
    .out_valid(out_valid8), .out_ready(out_ready8), .Data_Out(data_out8),
    .occupancy(occ8)
  );

  pipe_skid_reg #(.WIDTH(64), .RESET_VALUE(64'h0)) u64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid64), .in_ready(in_ready64), .Data_In(data_in64),
    .out_valid(out_valid64), .out_ready(out_ready64), .Data_Out(data_out64),
    .occupancy(occ64)
  );

  // One cycle on the 64-bit stage: drive, score the fire/accept decided by current flops, step past the edge.
  task automatic cyc64(input logic v, input logic [63:0] d, input logic r, input logic fl);
    logic [63:0] exp;
    in_valid64  = v;
    data_in64   = d;
    out_ready64 = r;
    flush       = fl;
    #1;
    if (out_valid64 && r) begin
      n_checks++;
      if (q64.size() == 0) begin
        n_fail++;
        $display("FAIL sb64_underflow: Data_Out=%h delivered, nothing expected", data_out64);
      end else begin
        exp = q64.pop_front();
        if (data_out64 !== exp) begin
          n_fail++;
          $display("FAIL sb64_order: Data_Out=%h expected %h", data_out64, exp);
        end
      end
    end
    if (v && in_ready64 && !fl) q64.push_back(d);
    @(posedge clk);
    #1;
    if (fl) q64.delete();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    cyc64(1'b1, 64'h1, 1'b0, 1'b0);
    cyc64(1'b1, 64'h2, 1'b0, 1'b0);
    n_checks++;
    if (occ64 !== 2'd2) begin
      n_fail++;
      $display("FAIL reset_prefill_occ: occupancy=%0d expected 2", occ64);
    end
    // Reset mid-transfer, away from any clock edge; outputs must clear immediately.
    in_valid64 = 1'b1;
    data_in64  = 64'h3;
    reset      = 1'b1;
    #1;
    n_checks++;
    if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1 || occ64 !== 2'd0 || data_out64 !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_async: out_valid=%b in_ready=%b occ=%0d Data_Out=%h expected 0 1 0 0",
               out_valid64, in_ready64, occ64, data_out64);
    end
    n_checks++;
    if (data_out8 !== 8'hA5 || out_valid8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_value8: Data_Out=%h out_valid=%b expected a5 0", data_out8, out_valid8);
    end
    #1;
    reset = 1'b0;
    q64.delete();
    // First accept on the first edge after release.
    cyc64(1'b1, 64'hC0DE, 1'b1, 1'b0);
    n_checks++;
    if (out_valid64 !== 1'b1 || data_out64 !== 64'hC0DE) begin
      n_fail++;
      $display("FAIL reset_release: out_valid=%b Data_Out=%h expected 1 c0de", out_valid64, data_out64);
    end
    cyc64(1'b0, 64'h0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [63:0] vals[4];
    vals = '{64'h11, 64'h22, 64'h33, 64'h44};
    for (int i = 0; i < 4; i++) begin
      cyc64(1'b1, vals[i], 1'b1, 1'b0);
      n_checks++;
      if (data_out64 !== vals[i] || occ64 !== 2'd1 || in_ready64 !== 1'b1 || out_valid64 !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_%0d: Data_Out=%h occ=%0d in_ready=%b expected %h 1 1",
                 i, data_out64, occ64, in_ready64, vals[i]);
      end
    end
    cyc64(1'b0, 64'h0, 1'b1, 1'b0);
    n_checks++;
    if (out_valid64 !== 1'b0 || occ64 !== 2'd0) begin
      n_fail++;
      $display("FAIL stream_drain: out_valid=%b occ=%0d expected 0 0", out_valid64, occ64);
    end
  endtask

  task automatic test_backpressure();
    cyc64(1'b1, 64'hA1, 1'b1, 1'b0);
    cyc64(1'b1, 64'hA2, 1'b1, 1'b0);
    cyc64(1'b1, 64'hA3, 1'b0, 1'b0);
    n_checks++;
    if (occ64 !== 2'd2 || in_ready64 !== 1'b0 || data_out64 !== 64'hA2) begin
      n_fail++;
      $display("FAIL bp_skid: occ=%0d in_ready=%b Data_Out=%h expected 2 0 a2", occ64, in_ready64, data_out64);
    end
    cyc64(1'b1, 64'hA4, 1'b0, 1'b0);
    n_checks++;
    if (occ64 !== 2'd2 || data_out64 !== 64'hA2 || out_valid64 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold: occ=%0d Data_Out=%h expected 2 a2", occ64, data_out64);
    end
    cyc64(1'b1, 64'hA4, 1'b1, 1'b0);
    n_checks++;
    if (in_ready64 !== 1'b1 || occ64 !== 2'd1 || data_out64 !== 64'hA3) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%b occ=%0d Data_Out=%h expected 1 1 a3", in_ready64, occ64, data_out64);
    end
    cyc64(1'b1, 64'hA4, 1'b1, 1'b0);
    cyc64(1'b0, 64'h0, 1'b1, 1'b0);
    n_checks++;
    if (out_valid64 !== 1'b0 || q64.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain: out_valid=%b pending=%0d expected 0 0", out_valid64, q64.size());
    end
  endtask

  task automatic test_flush();
    cyc64(1'b1, 64'hB1, 1'b0, 1'b0);
    cyc64(1'b1, 64'hB2, 1'b0, 1'b0);
    cyc64(1'b1, 64'h55, 1'b0, 1'b1);
    n_checks++;
    if (occ64 !== 2'd0 || out_valid64 !== 1'b0 || data_out64 !== 64'h0 || in_ready64 !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_two: occ=%0d out_valid=%b Data_Out=%h in_ready=%b expected 0 0 0 1",
               occ64, out_valid64, data_out64, in_ready64);
    end
    // Flush in ONE with in_ready high: the offered word and the fired word both vanish from the stage.
    cyc64(1'b1, 64'hB3, 1'b1, 1'b0);
    cyc64(1'b1, 64'h66, 1'b1, 1'b1);
    n_checks++;
    if (occ64 !== 2'd0 || out_valid64 !== 1'b0 || data_out64 !== 64'h0) begin
      n_fail++;
      $display("FAIL flush_one: occ=%0d out_valid=%b Data_Out=%h expected 0 0 0", occ64, out_valid64, data_out64);
    end
    cyc64(1'b1, 64'h77, 1'b1, 1'b0);
    n_checks++;
    if (data_out64 !== 64'h77 || occ64 !== 2'd1) begin
      n_fail++;
      $display("FAIL flush_resume: Data_Out=%h occ=%0d expected 77 1", data_out64, occ64);
    end
    cyc64(1'b0, 64'h0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic        stall8 = 1'b0, stall64 = 1'b0;
    logic [7:0]  prev8 = '0, exp8;
    logic [63:0] prev64 = '0, exp64;
    in_valid8 = 1'b0;
    in_valid64 = 1'b0;
    q8.delete();
    q64.delete();
    for (int c = 0; c < 10000; c++) begin
      n_checks += 2;
      if (in_ready8 !== (occ8 != 2'd2)) begin
        n_fail++;
        $display("FAIL rnd8_ready c%0d: in_ready=%b occ=%0d", c, in_ready8, occ8);
      end
      if (in_ready64 !== (occ64 != 2'd2)) begin
        n_fail++;
        $display("FAIL rnd64_ready c%0d: in_ready=%b occ=%0d", c, in_ready64, occ64);
      end
      if (stall8) begin
        n_checks++;
        if (data_out8 !== prev8 || out_valid8 !== 1'b1) begin
          n_fail++;
          $display("FAIL rnd8_stall c%0d: Data_Out=%h out_valid=%b expected %h 1", c, data_out8, out_valid8, prev8);
        end
      end
      if (stall64) begin
        n_checks++;
        if (data_out64 !== prev64 || out_valid64 !== 1'b1) begin
          n_fail++;
          $display("FAIL rnd64_stall c%0d: Data_Out=%h out_valid=%b expected %h 1", c, data_out64, out_valid64, prev64);
        end
      end
      // Upstream keeps a refused word stable until it is taken.
      if (!(in_valid8 && !in_ready8)) begin
        in_valid8 = 1'($urandom_range(0, 1));
        data_in8  = 8'($urandom);
      end
      if (!(in_valid64 && !in_ready64)) begin
        in_valid64 = 1'($urandom_range(0, 1));
        data_in64  = {$urandom, $urandom};
      end
      out_ready8  = 1'($urandom_range(0, 1));
      out_ready64 = 1'($urandom_range(0, 1));
      if (out_valid8 && out_ready8) begin
        n_checks++;
        exp8 = (q8.size() != 0) ? q8.pop_front() : ~data_out8;
        if (data_out8 !== exp8) begin
          n_fail++;
          $display("FAIL rnd8_order c%0d: Data_Out=%h expected %h", c, data_out8, exp8);
        end
      end
      if (out_valid64 && out_ready64) begin
        n_checks++;
        exp64 = (q64.size() != 0) ? q64.pop_front() : ~data_out64;
        if (data_out64 !== exp64) begin
          n_fail++;
          $display("FAIL rnd64_order c%0d: Data_Out=%h expected %h", c, data_out64, exp64);
        end
      end
      if (in_valid8 && in_ready8) q8.push_back(data_in8);
      if (in_valid64 && in_ready64) q64.push_back(data_in64);
      stall8  = out_valid8 && !out_ready8;
      stall64 = out_valid64 && !out_ready64;
      prev8   = data_out8;
      prev64  = data_out64;
      @(posedge clk);
      #1;
    end
    // Drain whatever is still held and confirm the scoreboards empty out with it.
    in_valid8   = 1'b0;
    in_valid64  = 1'b0;
    out_ready8  = 1'b1;
    out_ready64 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (out_valid8) begin
        n_checks++;
        exp8 = (q8.size() != 0) ? q8.pop_front() : ~data_out8;
        if (data_out8 !== exp8) begin
          n_fail++;
          $display("FAIL drain8_order: Data_Out=%h expected %h", data_out8, exp8);
        end
      end
      if (out_valid64) begin
        n_checks++;
        exp64 = (q64.size() != 0) ? q64.pop_front() : ~data_out64;
        if (data_out64 !== exp64) begin
          n_fail++;
          $display("FAIL drain64_order: Data_Out=%h expected %h", data_out64, exp64);
        end
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (q8.size() != 0 || q64.size() != 0 || out_valid8 !== 1'b0 || out_valid64 !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: pending8=%0d pending64=%0d out_valid=%b/%b expected 0 0 0/0",
               q8.size(), q64.size(), out_valid8, out_valid64);
    end
  endtask

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    in_valid8   = 1'b0;
    data_in8    = '0;
    out_ready8  = 1'b0;
    in_valid64  = 1'b0;
    data_in64   = '0;
    out_ready64 = 1'b0;
    #12;
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1 || occ64 !== 2'd0 || data_out8 !== 8'hA5) begin
      n_fail++;
      $display("FAIL initial_reset: out_valid=%b in_ready=%b occ=%0d Data_Out8=%h expected 0 1 0 a5",
               out_valid64, in_ready64, occ64, data_out8);
    end
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
